// File: rtl/gate_sensor_decoder.sv
// Two-beam gate decoder: synchronizes and debounces the outer (A) and inner (B) beams,
// then tracks complete entry/exit passages and flags illegal sequences or stalls.
module gate_sensor_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensorA,
  input  logic sensorB,
  output logic carIn,
  output logic carOut,
  output logic busy,
  output logic error,
  output logic faulted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_BA = 3'd5,
    OUT_A  = 3'd6,
    FAULT  = 3'd7
  } state_t;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        s1_a_r, s2_a_r, s1_b_r, s2_b_r;
  logic        da_r, db_r;
  logic [7:0]  cnt_a_r, cnt_b_r;
  logic [15:0] tmo_r;
  state_t      state_r, nxt_dec_s, nxt_s;
  logic [1:0]  code_s;
  logic        passage_s, tmo_hit_s, in_done_s, out_done_s;

  assign code_s = {da_r, db_r};

  // Synchronizers and debouncers for both beams
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a_r  <= 1'b0;
      s2_a_r  <= 1'b0;
      s1_b_r  <= 1'b0;
      s2_b_r  <= 1'b0;
      da_r    <= 1'b0;
      db_r    <= 1'b0;
      cnt_a_r <= 8'd0;
      cnt_b_r <= 8'd0;
    end else begin
      s1_a_r <= sensorA;
      s2_a_r <= s1_a_r;
      s1_b_r <= sensorB;
      s2_b_r <= s1_b_r;
      if (s2_a_r == da_r) begin
        cnt_a_r <= 8'd0;
      end else if (cnt_a_r == DB_LAST) begin
        da_r    <= s2_a_r;
        cnt_a_r <= 8'd0;
      end else begin
        cnt_a_r <= cnt_a_r + 8'd1;
      end
      if (s2_b_r == db_r) begin
        cnt_b_r <= 8'd0;
      end else if (cnt_b_r == DB_LAST) begin
        db_r    <= s2_b_r;
        cnt_b_r <= 8'd0;
      end else begin
        cnt_b_r <= cnt_b_r + 8'd1;
      end
    end
  end

  // Next-state decode from the debounced beam code, with the stall timeout on top
  always_comb begin
    nxt_dec_s  = state_r;
    in_done_s  = 1'b0;
    out_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        case (code_s)
          2'b10:   nxt_dec_s = IN_A;
          2'b01:   nxt_dec_s = OUT_B;
          2'b11:   nxt_dec_s = FAULT;
          default: nxt_dec_s = IDLE;
        endcase
      end
      IN_A: begin
        case (code_s)
          2'b11:   nxt_dec_s = IN_AB;
          2'b00:   nxt_dec_s = IDLE;
          2'b01:   nxt_dec_s = FAULT;
          default: nxt_dec_s = IN_A;
        endcase
      end
      IN_AB: begin
        case (code_s)
          2'b01:   nxt_dec_s = IN_B;
          2'b10:   nxt_dec_s = IN_A;
          2'b00:   nxt_dec_s = FAULT;
          default: nxt_dec_s = IN_AB;
        endcase
      end
      IN_B: begin
        case (code_s)
          2'b00: begin
            nxt_dec_s = IDLE;
            in_done_s = 1'b1;
          end
          2'b11:   nxt_dec_s = IN_AB;
          2'b10:   nxt_dec_s = FAULT;
          default: nxt_dec_s = IN_B;
        endcase
      end
      OUT_B: begin
        case (code_s)
          2'b11:   nxt_dec_s = OUT_BA;
          2'b00:   nxt_dec_s = IDLE;
          2'b10:   nxt_dec_s = FAULT;
          default: nxt_dec_s = OUT_B;
        endcase
      end
      OUT_BA: begin
        case (code_s)
          2'b10:   nxt_dec_s = OUT_A;
          2'b01:   nxt_dec_s = OUT_B;
          2'b00:   nxt_dec_s = FAULT;
          default: nxt_dec_s = OUT_BA;
        endcase
      end
      OUT_A: begin
        case (code_s)
          2'b00: begin
            nxt_dec_s  = IDLE;
            out_done_s = 1'b1;
          end
          2'b11:   nxt_dec_s = OUT_BA;
          2'b01:   nxt_dec_s = FAULT;
          default: nxt_dec_s = OUT_A;
        endcase
      end
      FAULT: begin
        if (code_s == 2'b00) begin
          nxt_dec_s = IDLE;
        end else begin
          nxt_dec_s = FAULT;
        end
      end
      default: nxt_dec_s = FAULT;
    endcase
    passage_s = (state_r != IDLE) && (state_r != FAULT);
    // A stall only counts when the beams asked for no move this cycle
    tmo_hit_s = passage_s && (nxt_dec_s == state_r) && (tmo_r == TO_LAST);
    if (tmo_hit_s) begin
      nxt_s = FAULT;
    end else begin
      nxt_s = nxt_dec_s;
    end
  end

  // State register, timeout counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      tmo_r   <= 16'd0;
      carIn   <= 1'b0;
      carOut  <= 1'b0;
      busy    <= 1'b0;
      error   <= 1'b0;
      faulted <= 1'b0;
    end else begin
      state_r <= nxt_s;
      carIn   <= in_done_s;
      carOut  <= out_done_s;
      busy    <= (nxt_s != IDLE);
      faulted <= (nxt_s == FAULT);
      error   <= (nxt_s == FAULT) && (state_r != FAULT);
      if ((nxt_s != state_r) || !passage_s) begin
        tmo_r <= 16'd0;
      end else begin
        tmo_r <= tmo_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Randomized and directed bench for gate_sensor_decoder against a passage-level
// reference model (sample-window debounce, sequence-position passage tracking).
module tb_gate_sensor_decoder;

  localparam int D  = 4;
  localparam int T  = 50;
  localparam int HW = D + 2;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_IN   = 2'd1;
  localparam logic [1:0] K_OUT  = 2'd2;
  localparam logic [1:0] K_FLT  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  pos;
    logic [15:0] age;
    logic        cin;
    logic        cout;
    logic        err;
  } mst_t;

  logic clk, reset, sensorA, sensorB;
  logic carIn, carOut, busy, error, faulted;

  int total = 0;
  int bad   = 0;
  int cin_cnt = 0, cout_cnt = 0, err_cnt = 0, busy_seen = 0;

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .sensorA(sensorA), .sensorB(sensorB),
    .carIn(carIn), .carOut(carOut), .busy(busy), .error(error), .faulted(faulted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beam code at position idx of a passage; exits are entries with A/B swapped
  function automatic logic [1:0] seq_code(input logic [1:0] kind, input int idx);
    logic [1:0] c;
    case (idx)
      0:       c = 2'b10;
      1:       c = 2'b11;
      2:       c = 2'b01;
      default: c = 2'b00;
    endcase
    if (kind == K_OUT) c = {c[0], c[1]};
    return c;
  endfunction

  // Debounced value flips once the last D synchronized samples all disagree with it
  function automatic logic window_flip(input logic [HW-1:0] h, input logic d);
    for (int i = 1; i <= D; i++) begin
      if (h[i] == d) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic mst_t step(input mst_t c, input logic [1:0] code);
    mst_t n;
    int p;
    n = c;
    n.cin = 1'b0;
    n.cout = 1'b0;
    n.err = 1'b0;
    p = int'(c.pos);
    if (c.kind == K_IDLE) begin
      if (code == 2'b10) begin
        n.kind = K_IN; n.pos = 2'd0; n.age = 16'd0;
      end else if (code == 2'b01) begin
        n.kind = K_OUT; n.pos = 2'd0; n.age = 16'd0;
      end else if (code == 2'b11) begin
        n.kind = K_FLT; n.err = 1'b1;
      end
    end else if (c.kind == K_FLT) begin
      if (code == 2'b00) n.kind = K_IDLE;
    end else if (code == seq_code(c.kind, p)) begin
      if (c.age == 16'(T - 1)) begin
        n.kind = K_FLT; n.err = 1'b1; n.age = 16'd0;
      end else begin
        n.age = c.age + 16'd1;
      end
    end else if (code == seq_code(c.kind, p + 1)) begin
      if (p == 2) begin
        n.kind = K_IDLE;
        n.cin  = (c.kind == K_IN);
        n.cout = (c.kind == K_OUT);
      end else begin
        n.pos = c.pos + 2'd1; n.age = 16'd0;
      end
    end else if (code == seq_code(c.kind, p - 1)) begin
      if (p == 0) begin
        n.kind = K_IDLE;
      end else begin
        n.pos = c.pos - 2'd1; n.age = 16'd0;
      end
    end else begin
      n.kind = K_FLT; n.err = 1'b1;
    end
    return n;
  endfunction

  logic [HW-1:0] ha, hb;
  logic          m_da, m_db;
  mst_t          m;

  // Reference model: raw-sample history, debounced levels and passage state
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ha <= '0; hb <= '0; m_da <= 1'b0; m_db <= 1'b0; m <= '0;
    end else begin
      ha <= {ha[HW-2:0], sensorA};
      hb <= {hb[HW-2:0], sensorB};
      if (window_flip(ha, m_da)) m_da <= ~m_da;
      if (window_flip(hb, m_db)) m_db <= ~m_db;
      m <= step(m, {m_da, m_db});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse counters for directed checks
  always @(negedge clk) begin
    chk("carIn",   int'(carIn),   int'(m.cin));
    chk("carOut",  int'(carOut),  int'(m.cout));
    chk("error",   int'(error),   int'(m.err));
    chk("busy",    int'(busy),    int'(m.kind != K_IDLE));
    chk("faulted", int'(faulted), int'(m.kind == K_FLT));
    chk("in_out_exclusive", int'(carIn & carOut), 0);
    cin_cnt   += int'(carIn);
    cout_cnt  += int'(carOut);
    err_cnt   += int'(error);
    busy_seen += int'(busy);
  end

  task automatic drive(input logic a, input logic b);
    @(posedge clk);
    #2;
    sensorA = a;
    sensorB = b;
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    drive(a, b);
    repeat (n - 1) @(posedge clk);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return carIn;
      1:       return carOut;
      2:       return error;
      default: return busy;
    endcase
  endfunction

  // Edges elapsed until the selected output is seen high; -1 if the budget expires
  task automatic wait_for(input int sel, input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pick(sel) && edges < 0) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  int c0, o0, e0, lat;

  initial begin
    reset = 1'b1; sensorA = 1'b0; sensorB = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_faulted", int'(faulted), 0);
    reset = 1'b0;
    hold(1'b0, 1'b0, 20);

    // Full entry
    c0 = cin_cnt; o0 = cout_cnt; e0 = err_cnt;
    hold(1'b1, 1'b0, 20);
    chk("entry_busy", int'(busy), 1);
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0);
    wait_for(0, 20, lat);
    chk("entry_latency", lat - 1, 6);
    hold(1'b0, 1'b0, 14);
    chk("entry_carIn_count", cin_cnt - c0, 1);
    chk("entry_carOut_count", cout_cnt - o0, 0);
    chk("entry_error_count", err_cnt - e0, 0);
    chk("entry_idle", int'(busy), 0);

    // Full exit
    c0 = cin_cnt; o0 = cout_cnt;
    hold(1'b0, 1'b1, 20); hold(1'b1, 1'b1, 20); hold(1'b1, 1'b0, 20); hold(1'b0, 1'b0, 20);
    chk("exit_carOut_count", cout_cnt - o0, 1);
    chk("exit_carIn_count", cin_cnt - c0, 0);

    // Reversal then abort
    c0 = cin_cnt; o0 = cout_cnt; e0 = err_cnt;
    hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b1, 1'b0, 20); hold(1'b0, 1'b0, 20);
    chk("abort_pulses", (cin_cnt - c0) + (cout_cnt - o0) + (err_cnt - e0), 0);
    chk("abort_idle", int'(busy), 0);

    // Illegal jump from IDLE
    e0 = err_cnt;
    hold(1'b1, 1'b1, 20);
    chk("illegal_faulted", int'(faulted), 1);
    chk("illegal_error_count", err_cnt - e0, 1);
    hold(1'b0, 1'b0, 20);
    chk("illegal_recovered", int'(faulted), 0);

    // Short glitch on A
    busy_seen = 0;
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 20);
    chk("glitch_busy_seen", busy_seen, 0);

    // Stall timeout in IN_A
    e0 = err_cnt;
    drive(1'b1, 1'b0);
    wait_for(3, 20, lat);
    chk("timeout_busy_latency", lat - 1, 6);
    wait_for(2, 80, lat);
    chk("timeout_cycles", lat, 50);
    repeat (20) @(posedge clk);
    #2;
    chk("timeout_faulted", int'(faulted), 1);
    chk("timeout_error_count", err_cnt - e0, 1);
    hold(1'b0, 1'b0, 20);
    chk("timeout_recovered", int'(faulted), 0);

    // Reset while in IN_B
    c0 = cin_cnt;
    hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b0, 1'b1, 20);
    chk("inb_busy", int'(busy), 1);
    @(posedge clk);
    #2;
    reset = 1'b1; sensorA = 1'b0; sensorB = 1'b0;
    #1;
    chk("midreset_outputs", int'({carIn, carOut, busy, error, faulted}), 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    hold(1'b0, 1'b0, 30);
    chk("midreset_no_carIn", cin_cnt - c0, 0);
    chk("midreset_idle", int'(busy), 0);

    // Randomized segments, occasionally long enough to stall or interrupted by reset
    for (int s = 0; s < 220; s++) begin
      int code, len;
      code = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(40, 70);
      else len = $urandom_range(1, 14);
      hold(code[1], code[0], len);
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
    end
    hold(1'b0, 1'b0, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_sensor_decoder.md
GATE_SENSOR_DECODER -- requirements
Module: gate_sensor_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized sensor must differ before its debounced value changes (legal 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000: cycles without a state change in a passage state before a fault is declared (legal 2..65535).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sensorA  input  1  outer photo-beam, asynchronous raw input, 1 = beam blocked.
REQ-006 sensorB  input  1  inner photo-beam, asynchronous raw input, 1 = beam blocked.
REQ-007 carIn  output  1  single-cycle pulse, one completed entry; drives the parking counter's increment input.
REQ-008 carOut  output  1  single-cycle pulse, one completed exit; drives the parking counter's decrement input.
REQ-009 busy  output  1  level, high whenever state is not IDLE.
REQ-010 error  output  1  single-cycle pulse on every entry into FAULT.
REQ-011 faulted  output  1  level, high while state is FAULT.

Function
REQ-012 Each sensor SHALL pass through a two-flop synchronizer (s1, s2) and then a debouncer producing a registered debounced value dA or dB.
REQ-013 Debouncer: the counter clears on any edge where s2 == d; d takes s2 on the DEBOUNCE_CYCLES-th consecutive edge where s2 != d; the counter then clears.
REQ-014 The FSM SHALL decode only {dA,dB} and have states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, FAULT.
REQ-015 IDLE: 10->IN_A; 01->OUT_B; 11->FAULT; 00 stay.
REQ-016 IN_A: 11->IN_AB; 00->IDLE with no pulse (aborted); 01->FAULT; 10 stay.
REQ-017 IN_AB: 01->IN_B; 10->IN_A (car reversing); 00->FAULT; 11 stay.
REQ-018 IN_B: 00->IDLE and assert carIn; 11->IN_AB; 10->FAULT; 01 stay.
REQ-019 OUT_B, OUT_BA and OUT_A SHALL mirror REQ-016..018 with A and B swapped, and OUT_A on 00 SHALL go to IDLE and assert carOut.
REQ-020 FAULT: stay while {dA,dB} != 00; 00->IDLE with no pulse.
REQ-021 carIn/carOut SHALL be registered, high exactly for the one cycle following the transition edge, and SHALL never be high together.
REQ-022 Latency: a raw change stable before edge k SHALL update d at edge k+1+DEBOUNCE_CYCLES and the FSM state/pulse at edge k+2+DEBOUNCE_CYCLES.
REQ-023 A 16-bit timeout counter SHALL count edges spent in any IN_* or OUT_* state, and SHALL clear on every state change and in IDLE and FAULT.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1 and no other transition applies, the FSM SHALL enter FAULT on the next edge.
REQ-025 Every entry into FAULT (illegal code or timeout) SHALL produce exactly one error pulse, in the cycle after the entry edge.
REQ-026 Raw glitches shorter than DEBOUNCE_CYCLES cycles SHALL cause no change in the FSM state.

Reset
REQ-027 While reset is high, all of the following SHALL be held: state = IDLE; s1, s2, dA, dB = 0; all counters = 0; carIn, carOut, error = 0; busy, faulted = 0.
REQ-028 Reset asserted mid-passage SHALL abort the passage with no carIn/carOut pulse, and the FSM SHALL resume from IDLE using the debounced sensor values after release.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-029 Full entry: AB = 00,10,11,01,00, each held 20 cycles -> exactly one carIn pulse, 6 cycles after the final raw change; carOut and error stay 0; busy stays high from 10 until 00.
REQ-030 Full exit: AB = 00,01,11,10,00 -> exactly one carOut pulse; carIn stays 0.
REQ-031 Reversal and abort: AB = 10,11,10,00 -> state returns to IDLE; no pulses; error = 0.
REQ-032 Illegal jump and glitch: from IDLE, AB = 11 for 20 cycles, then 00 -> one error pulse, faulted is high until the debounced 00 is seen, then IDLE. Separately, a 3-cycle pulse on sensorA -> busy stays 0.
REQ-033 Timeout: AB = 10 held for 80 cycles -> FAULT entered 50 cycles after IN_A entry; one error pulse; faulted stays high until AB = 00.
REQ-034 Reset in IN_B: assert reset for 3 cycles -> all outputs 0 immediately, and no carIn pulse follows.
